spi_master: RTL and testbench

SPI bus master that drives sclk, ss and mosi, and captures miso, for one bits_num-wide word per transfer. It is the initiator-side counterpart of the slave block on the same bus. It emits a one-cycle tx_end strobe so the slave can latch its received word. It sits between a local host (start/data_in/data_out/busy) and the four-wire SPI pins.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_clk_gen.sv | 38 +++
 rtl/spi_master.sv | 153 +++++++++++++++
 tb/tb_spi_master.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: bus mode encodings, FSM states and
// the sizing helper for the sclk edge counter.
package spi_pkg;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } spi_state_e;

  // Counter width able to index every sclk edge of one word (0..2*bits-1).
  function automatic int unsigned edge_cnt_width(input int unsigned bits);
    return $clog2(2 * bits);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Divider producing a one-cycle tick every CLK_DIV clocks while enabled;
// the count restarts from zero whenever en is low.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = $clog2(CLK_DIV + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI bus master: shifts one bits_num-wide word out on mosi (MSB first) while
// capturing miso, with selectable CPOL/CPHA and a one-cycle tx_end strobe.
module spi_master
  import spi_pkg::*;
#(
  parameter logic [1:0]  mode     = MODE0,
  parameter int unsigned bits_num = 8,
  parameter int unsigned CLK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [bits_num-1:0] data_in,
  input  logic                miso,
  output logic                sclk,
  output logic                ss,
  output logic                mosi,
  output logic                tx_end,
  output logic                busy,
  output logic [bits_num-1:0] data_out
);

  localparam logic Cpol = mode[1];
  localparam logic Cpha = mode[0];
  localparam int unsigned EdgeW = edge_cnt_width(bits_num);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * bits_num - 1);

  spi_state_e          state_q, state_d;
  logic                sclk_q, sclk_d;
  logic                ss_q, ss_d;
  logic                mosi_q, mosi_d;
  logic                tx_end_q, tx_end_d;
  logic                busy_q, busy_d;
  logic [bits_num-1:0] data_out_q, data_out_d;
  logic [bits_num-1:0] tx_shift_q, tx_shift_d;
  logic [bits_num-1:0] rx_shift_q, rx_shift_d;
  logic [EdgeW-1:0]    edge_cnt_q, edge_cnt_d;

  logic div_en;
  logic tick;
  logic lead_edge;

  assign div_en    = (state_q != IDLE);
  assign lead_edge = ~edge_cnt_q[0];

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk  (clk),
    .reset(reset),
    .en   (div_en),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    sclk_d     = sclk_q;
    ss_d       = ss_q;
    mosi_d     = mosi_q;
    tx_end_d   = 1'b0;
    busy_d     = busy_q;
    data_out_d = data_out_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    edge_cnt_d = edge_cnt_q;

    unique case (state_q)
      IDLE: begin
        // The cycle carrying tx_end belongs to the finished transfer.
        if (start && !tx_end_q) begin
          state_d    = LEAD;
          ss_d       = 1'b0;
          busy_d     = 1'b1;
          edge_cnt_d = '0;
          rx_shift_d = '0;
          if (Cpha) begin
            tx_shift_d = data_in;
          end else begin
            mosi_d     = data_in[bits_num-1];
            tx_shift_d = data_in << 1;
          end
        end
      end

      // The tick closing LEAD already produces edge 0, so toggles land exactly
      // CLK_DIV cycles apart starting CLK_DIV cycles after ss falls.
      LEAD, XFER: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          if (lead_edge ^ Cpha) begin
            rx_shift_d = {rx_shift_q[bits_num-2:0], miso};
          end else if (edge_cnt_q != LastEdge) begin
            mosi_d     = tx_shift_q[bits_num-1];
            tx_shift_d = tx_shift_q << 1;
          end
          if (edge_cnt_q == LastEdge) begin
            state_d    = TRAIL;
            edge_cnt_d = '0;
          end else begin
            state_d    = XFER;
            edge_cnt_d = edge_cnt_q + 1'b1;
          end
        end
      end

      TRAIL: begin
        if (tick) begin
          state_d    = IDLE;
          ss_d       = 1'b1;
          tx_end_d   = 1'b1;
          busy_d     = 1'b0;
          data_out_d = rx_shift_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sclk_q     <= Cpol;
      ss_q       <= 1'b1;
      mosi_q     <= 1'b0;
      tx_end_q   <= 1'b0;
      busy_q     <= 1'b0;
      data_out_q <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      edge_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sclk_q     <= sclk_d;
      ss_q       <= ss_d;
      mosi_q     <= mosi_d;
      tx_end_q   <= tx_end_d;
      busy_q     <= busy_d;
      data_out_q <= data_out_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign sclk     = sclk_q;
  assign ss       = ss_q;
  assign mosi     = mosi_q;
  assign tx_end   = tx_end_q;
  assign busy     = busy_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: several mode/width/divider configurations, each with a
// pin-level slave model, a scoreboard queue and an independent monitor.
module tb_spi_master;

  localparam int NCfg = 5;

  typedef struct {
    logic [15:0] mw;
    logic [15:0] sw;
    int          t0;
    logic        mosi0;
  } exp_t;

  logic clk;
  int   cyc;
  int   n_tests;
  int   n_fail;
  bit   done_v [NCfg];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input int g, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s: got 0x%0h, want 0x%0h", g, nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  for (genvar g = 0; g < NCfg; g++) begin : g_cfg
    localparam logic [1:0] M = (g == 0) ? 2'b00 : (g == 1) ? 2'b11 :
                               (g == 2) ? 2'b01 : (g == 3) ? 2'b10 : 2'b01;
    localparam int unsigned N = (g == 3) ? 16 : (g == 4) ? 5 : 8;
    localparam int unsigned D = (g == 3) ? 1 : (g == 4) ? 3 : 2;
    localparam logic CPOL = M[1];
    localparam logic CPHA = M[0];
    localparam int unsigned Span = (2 * N + 1) * D;

    logic         rst_n, start, miso;
    logic [N-1:0] din, dout;
    logic         sclk, ss, mosi, tx_end, busy;
    logic [15:0]  slave_next;
    logic [N-1:0] s_rx;
    exp_t         q[$];
    int           last_te;
    int           last_t0;
    logic         mosi_idle;

    spi_master #(
      .mode    (M),
      .bits_num(N),
      .CLK_DIV (D)
    ) u_dut (
      .clk     (clk),
      .reset   (rst_n),
      .start   (start),
      .data_in (din),
      .miso    (miso),
      .sclk    (sclk),
      .ss      (ss),
      .mosi    (mosi),
      .tx_end  (tx_end),
      .busy    (busy),
      .data_out(dout)
    );

    // Slave side of the bus: presents its word MSB first, captures mosi.
    initial begin : slave
      logic         act, prev, lead;
      logic [N-1:0] tx;
      act = 1'b0; prev = CPOL; tx = '0; s_rx = '0; miso = 1'b0;
      forever begin
        @(negedge clk);
        if (ss) begin
          act = 1'b0;
        end else if (!act) begin
          act  = 1'b1;
          tx   = slave_next[N-1:0];
          s_rx = '0;
          prev = sclk;
          if (!CPHA) miso = tx[N-1];
        end else if (sclk !== prev) begin
          prev = sclk;
          lead = (sclk != CPOL);
          if (lead != CPHA) begin
            s_rx = {s_rx[N-2:0], mosi};
          end else if (CPHA) begin
            miso = tx[N-1];
            tx   = tx << 1;
          end else begin
            tx   = tx << 1;
            miso = tx[N-1];
          end
        end
      end
    end

    initial begin : monitor
      logic ss_p, sclk_p, te_p;
      int   tog, tog_bad, busy_bad;
      exp_t e;
      ss_p = 1'b1; sclk_p = CPOL; te_p = 1'b0;
      tog = 0; tog_bad = 0; busy_bad = 0;
      forever begin
        @(negedge clk);
        if (te_p) check(g, "tx_end_one_cycle", 32'(tx_end), 32'd0);
        if (ss_p && !ss) begin
          check(g, "xfer_pending_at_ss_fall", 32'(q.size() != 0), 32'd1);
          tog = 0; tog_bad = 0; busy_bad = 0;
          if (q.size() != 0) begin
            e = q[0];
            check(g, "ss_fall_cycle", 32'(cyc), 32'(e.t0 + 1));
            check(g, "mosi_at_ss_fall", 32'(mosi), 32'(CPHA ? e.mosi0 : e.mw[N-1]));
          end
        end
        if (!ss && !busy) busy_bad++;
        if (!ss && sclk !== sclk_p && q.size() != 0) begin
          e = q[0];
          tog++;
          if (cyc != e.t0 + 1 + int'(D) * tog) tog_bad++;
          if (tog == 1) check(g, "mosi_at_first_edge", 32'(mosi), 32'(e.mw[N-1]));
        end
        if (tx_end) begin
          check(g, "xfer_pending_at_tx_end", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check(g, "master_data_out", 32'(dout), 32'(e.sw[N-1:0]));
            check(g, "slave_captured", 32'(s_rx), 32'(e.mw[N-1:0]));
            check(g, "sclk_toggles", 32'(tog), 32'(2 * N));
            check(g, "mistimed_toggles", 32'(tog_bad), 32'd0);
            check(g, "tx_end_cycle", 32'(cyc), 32'(e.t0 + 1 + int'(Span)));
            check(g, "sclk_idle_after", 32'(sclk), 32'(CPOL));
            check(g, "ss_high_at_end", 32'(ss), 32'd1);
            check(g, "busy_low_at_end", 32'(busy), 32'd0);
            check(g, "busy_while_selected", 32'(busy_bad), 32'd0);
          end
        end
        ss_p = ss; sclk_p = sclk; te_p = tx_end;
      end
    end

    // Issue one word; b2b holds start through the previous tx_end cycle (which
    // must be ignored), pulse_at>0 adds a start pulse that must not restart.
    task automatic xfer(input logic [15:0] mw, input logic [15:0] sw, input bit b2b,
                        input int pulse_at, input logic [15:0] pdat);
      int   t0;
      exp_t e;
      if (b2b && last_te >= 0) begin
        wait_cyc(last_te);
        start = 1'b1;
        din   = ~mw[N-1:0];
        wait_cyc(last_te + 1);
        t0 = last_te + 1;
      end else begin
        wait_cyc((cyc + int'($urandom_range(3, 0)) > last_te + 1) ?
                 cyc + int'($urandom_range(3, 0)) : last_te + 1);
        start = 1'b1;
        t0 = cyc;
      end
      din = mw[N-1:0];
      slave_next = sw;
      e.mw = mw; e.sw = sw; e.t0 = t0; e.mosi0 = mosi_idle;
      q.push_back(e);
      mosi_idle = mw[0];
      last_t0 = t0;
      last_te = t0 + 1 + int'(Span);
      wait_cyc(t0 + 1);
      start = 1'b0;
      din = N'($urandom);
      if (pulse_at > 0) begin
        wait_cyc(t0 + pulse_at);
        start = 1'b1;
        din = pdat[N-1:0];
        wait_cyc(t0 + pulse_at + 1);
        start = 1'b0;
        din = N'($urandom);
      end
    endtask

    initial begin : stim
      rst_n = 1'b1; start = 1'b0; din = '0; slave_next = '0;
      last_te = -1; last_t0 = 0; mosi_idle = 1'b0; done_v[g] = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      check(g, "reset_sclk", 32'(sclk), 32'(CPOL));
      check(g, "reset_ss", 32'(ss), 32'd1);
      check(g, "reset_mosi", 32'(mosi), 32'd0);
      check(g, "reset_tx_end", 32'(tx_end), 32'd0);
      check(g, "reset_busy", 32'(busy), 32'd0);
      check(g, "reset_data_out", 32'(dout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      if (g == 0) begin
        xfer(16'h00A5, 16'h003C, 1'b0, 0, 16'h0);
        xfer(16'h0012, 16'($urandom), 1'b0, 10, 16'h00FF);
        xfer(16'($urandom), 16'($urandom), 1'b0, 0, 16'h0);
        wait_cyc(last_t0 + 12);
        #2 rst_n = 1'b0;
        #1;
        check(g, "abort_ss", 32'(ss), 32'd1);
        check(g, "abort_sclk", 32'(sclk), 32'(CPOL));
        check(g, "abort_busy", 32'(busy), 32'd0);
        check(g, "abort_data_out", 32'(dout), 32'd0);
        q.delete();
        last_te = -1;
        mosi_idle = 1'b0;
        @(negedge clk);
        check(g, "abort_no_tx_end", 32'(tx_end), 32'd0);
        rst_n = 1'b1;
        xfer(16'h005A, 16'($urandom), 1'b0, 0, 16'h0);
      end else if (g == 1) begin
        xfer(16'h00F0, 16'h000F, 1'b0, 0, 16'h0);
      end else if (g == 2) begin
        xfer(16'h0081, 16'($urandom), 1'b0, 0, 16'h0);
      end else if (g == 3) begin
        xfer(16'hBEEF, 16'hBEEF, 1'b0, 0, 16'h0);
      end

      for (int i = 0; i < 8; i++) begin
        int p;
        p = ($urandom_range(1, 0) == 1) ? int'($urandom_range(Span - 1, 2)) : 0;
        xfer(16'($urandom), 16'($urandom), $urandom_range(1, 0) == 1, p, 16'($urandom));
      end
      wait_cyc(last_te + 4);
      done_v[g] = 1'b1;
    end
  end

  initial begin : top
    bit all_done;
    n_tests = 0;
    n_fail  = 0;
    all_done = 1'b0;
    while (!all_done && cyc < 20000) begin
      @(negedge clk);
      all_done = 1'b1;
      for (int i = 0; i < NCfg; i++) if (!done_v[i]) all_done = 1'b0;
    end
    for (int i = 0; i < NCfg; i++) check(i, "finished_in_time", 32'(done_v[i]), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
